// File: rtl/jk_counter_bank.sv
// rtl/jk_counter_bank.sv - bank of JK flip-flops with up/down count and parallel load modes
module jk_counter_bank #(
   parameter int          WIDTH     = 8,
   parameter logic [31:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic             tc,
   output logic             wrap
);

   localparam logic [1:0] MODE_JK   = 2'b00;
   localparam logic [1:0] MODE_UP   = 2'b01;
   localparam logic [1:0] MODE_DOWN = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   localparam logic [WIDTH-1:0] RST_Q = RESET_VAL[WIDTH-1:0];

   logic [WIDTH-1:0] up_t;
   logic [WIDTH-1:0] dn_t;
   logic [WIDTH-1:0] j_eff;
   logic [WIDTH-1:0] k_eff;
   logic [WIDTH-1:0] q_next;
   logic             carry;
   logic             borrow;

   // Toggle enables for counting: bit i flips when all lower bits are 1 (up) or 0 (down)
   always_comb begin
      up_t   = '0;
      dn_t   = '0;
      carry  = 1'b1;
      borrow = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         up_t[i] = carry;
         dn_t[i] = borrow;
         carry   = carry & q[i];
         borrow  = borrow & ~q[i];
      end
   end

   // Map each mode onto per-bit J/K inputs so every mode shares one JK update equation;
   // j/k are only routed through in JK mode, so X on them cannot reach q elsewhere
   always_comb begin
      j_eff = '0;
      k_eff = '0;
      case (mode)
         MODE_JK: begin
            j_eff = j;
            k_eff = k;
         end
         MODE_UP: begin
            j_eff = up_t;
            k_eff = up_t;
         end
         MODE_DOWN: begin
            j_eff = dn_t;
            k_eff = dn_t;
         end
         default: begin
            j_eff = load_val;
            k_eff = ~load_val;
         end
      endcase
      q_next = (j_eff & ~q) | (~k_eff & q);
   end

   // Terminal count lookahead: the next enabled edge in this mode wraps
   always_comb begin
      tc = ((mode == MODE_UP) && (&q)) || ((mode == MODE_DOWN) && (~|q));
   end

   // State register; qbar is stored from the same next value so it is always ~q
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q    <= RST_Q;
         qbar <= ~RST_Q;
         wrap <= 1'b0;
      end else begin
         wrap <= en & tc;
         if (en) begin
            q    <= q_next;
            qbar <= ~q_next;
         end
      end
   end

endmodule
